// File: rtl/dram_port_arbiter.sv
// ----------------------------------------------------------------------------
// dram_port_arbiter
//
// Shares one DRAM data port between two requesters:
//   port 0 : CPU load/store unit (single beats)
//   port 1 : trace/debug loader (single beats or locked incrementing bursts)
// Idle arbitration is round-robin on conflicts. A port 1 grant with a
// non-zero m1_len locks the DRAM to port 1 until the last burst beat is
// accepted. Every accepted beat returns the DRAM's combinational read data,
// registered at the accept edge, as a one-cycle response pulse. For writes
// this is the pre-write word.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   m0_valid/ready       port 0 request / beat accepted (combinational)
//   m0_addr/we/wdata     port 0 byte address, byte enables (0 = read), data
//   m0_rvalid/rdata      port 0 response pulse and data
//   m1_*                 same as port 0, plus:
//   m1_len               burst beats minus 1, sampled on the first beat
//   m1_busy              a port 1 burst lock is in progress
//   dram_a/we/d          DRAM word address, byte enables, write data
//   dram_spo             DRAM combinational read data
// ----------------------------------------------------------------------------
module dram_port_arbiter #(
    parameter int ADDR_BITS  = 16,
    parameter int BURST_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic [31:0]           m0_addr,
    input  logic [3:0]            m0_we,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,

    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic [31:0]           m1_addr,
    input  logic [3:0]            m1_we,
    input  logic [31:0]           m1_wdata,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,
    input  logic [BURST_BITS-1:0] m1_len,
    output logic                  m1_busy,

    output logic [ADDR_BITS-1:0]  dram_a,
    output logic [3:0]            dram_we,
    output logic [31:0]           dram_d,
    input  logic [31:0]           dram_spo
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                 state;
    state_t                 state_next;

    // Fairness pointer: most recent winner (1 = port 1).
    logic                   last;

    logic [ADDR_BITS-1:0]   base;
    logic [BURST_BITS-1:0]  beat;
    logic [BURST_BITS-1:0]  last_beat;
    logic [ADDR_BITS-1:0]   a_hold;
    logic [ADDR_BITS-1:0]   burst_addr;

    logic                   grant0;
    logic                   grant1;
    logic                   burst_start;

    // Byte-offset and upper address bits are not part of the word address.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[31:ADDR_BITS+2], m0_addr[1:0],
                                m1_addr[31:ADDR_BITS+2], m1_addr[1:0]};

    // Burst address wraps naturally by truncation to ADDR_BITS.
    assign burst_addr  = base + ADDR_BITS'(beat);
    assign burst_start = (state == IDLE) && grant1 && (m1_len != '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and grant decision
    // ------------------------------------------------------------------
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        // No beat is performed while reset is asserted.
        if (!rst) begin
            case (state)
                IDLE: begin
                    // On a conflict the port that did not win last time wins.
                    if (m0_valid && (!m1_valid || last)) begin
                        grant0 = 1'b1;
                    end else if (m1_valid) begin
                        grant1 = 1'b1;
                    end
                    if (grant1 && (m1_len != '0)) begin
                        state_next = BURST;
                    end
                end
                BURST: begin
                    // Port 0 is locked out; a low m1_valid stalls the burst.
                    grant1 = m1_valid;
                    if (m1_valid && (beat == last_beat)) begin
                        state_next = IDLE;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: handshakes and DRAM drive
    // ------------------------------------------------------------------
    always_comb begin
        m0_ready = grant0;
        m1_ready = grant1;
        m1_busy  = (state == BURST);
        dram_a   = a_hold;
        dram_we  = '0;
        dram_d   = '0;
        if (grant0) begin
            dram_a  = m0_addr[ADDR_BITS+1:2];
            dram_we = m0_we;
            dram_d  = m0_wdata;
        end else if (grant1) begin
            dram_a  = (state == BURST) ? burst_addr : m1_addr[ADDR_BITS+1:2];
            dram_we = m1_we;
            dram_d  = m1_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: fairness pointer, burst counter, responses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= 1'b1;
            base      <= '0;
            beat      <= '0;
            last_beat <= '0;
            a_hold    <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            // Remember the driven address so it holds when nobody is granted.
            a_hold    <= dram_a;
            m0_rvalid <= grant0;
            m1_rvalid <= grant1;

            if (grant0) begin
                m0_rdata <= dram_spo;
                last     <= 1'b0;
            end
            if (grant1) begin
                m1_rdata <= dram_spo;
                last     <= 1'b1;
            end

            // The first beat goes to base itself, so the counter starts at 1.
            if (burst_start) begin
                base      <= m1_addr[ADDR_BITS+1:2];
                beat      <= BURST_BITS'(1);
                last_beat <= m1_len;
            end else if ((state == BURST) && grant1) begin
                if (beat == last_beat) begin
                    beat <= '0;
                end else begin
                    beat <= beat + BURST_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dram_port_arbiter
//
// Directed stimulus with hand-computed expectations. Each stimulus cycle
// checks the handshake and DRAM drive, and pushes the expected response onto
// a per-port queue; an independent monitor pops and compares whenever the DUT
// raises an rvalid. DRAM word i is preloaded with 0xC0DE0000 | i, except word
// 0x10 which holds 0x11223344.
// ----------------------------------------------------------------------------
module tb_dram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_valid, m0_ready, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_we;
    logic        m1_valid, m1_ready, m1_rvalid, m1_busy;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_we;
    logic [7:0]  m1_len;
    logic [15:0] dram_a;
    logic [3:0]  dram_we;
    logic [31:0] dram_d;
    logic [31:0] dram_spo;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rsp_t;

    rsp_t q0[$];
    rsp_t q1[$];

    dram_port_arbiter #(.ADDR_BITS(16), .BURST_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_valid  (m0_valid),
        .m0_ready  (m0_ready),
        .m0_addr   (m0_addr),
        .m0_we     (m0_we),
        .m0_wdata  (m0_wdata),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_valid  (m1_valid),
        .m1_ready  (m1_ready),
        .m1_addr   (m1_addr),
        .m1_we     (m1_we),
        .m1_wdata  (m1_wdata),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_len    (m1_len),
        .m1_busy   (m1_busy),
        .dram_a    (dram_a),
        .dram_we   (dram_we),
        .dram_d    (dram_d),
        .dram_spo  (dram_spo)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // DRAM model: combinational read, byte-enabled write on the rising edge.
    logic [31:0] mem [0:65535];
    logic        mem_load;
    assign dram_spo = mem[dram_a];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
            mem[16'h0010] <= 32'h11223344;
        end else begin
            for (int b = 0; b < 4; b++)
                if (dram_we[b]) mem[dram_a][8*b +: 8] <= dram_d[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cycle, act, exp);
        end
    endtask

    // One stimulus cycle. eg = expected grant (-1 none, 0, 1); ea/erd are the
    // expected word address and response data of the granted beat; eb is the
    // expected m1_busy in this cycle.
    task automatic cyc(input logic r,
                       input logic v0, input logic [31:0] a0, input logic [3:0] we0, input logic [31:0] d0,
                       input logic v1, input logic [31:0] a1, input logic [3:0] we1, input logic [31:0] d1,
                       input logic [7:0] len, input int eg, input logic [15:0] ea,
                       input logic [31:0] erd, input logic eb);
        logic [3:0]  ewe;
        logic [31:0] ed;
        @(negedge clk);
        rst = r;
        m0_valid = v0; m0_addr = a0; m0_we = we0; m0_wdata = d0;
        m1_valid = v1; m1_addr = a1; m1_we = we1; m1_wdata = d1; m1_len = len;
        #1;
        ewe = (eg == 0) ? we0 : (eg == 1) ? we1 : 4'h0;
        ed  = (eg == 0) ? d0 : d1;
        chk("m0_ready", 32'(m0_ready), 32'(eg == 0));
        chk("m1_ready", 32'(m1_ready), 32'(eg == 1));
        chk("m1_busy",  32'(m1_busy),  32'(eb));
        chk("dram_we",  32'(dram_we),  32'(ewe));
        if (eg >= 0) chk("dram_a", 32'(dram_a), 32'(ea));
        if (ewe != 4'h0) chk("dram_d", dram_d, ed);
        if (eg == 0) q0.push_back('{cycle + 1, erd});
        if (eg == 1) q1.push_back('{cycle + 1, erd});
    endtask

    task automatic idle(input int eg_none_busy);
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 8'h0, -1, 16'h0, 32'h0, eg_none_busy != 0);
    endtask

    // Response monitor: responses must arrive exactly one cycle after accept.
    always @(negedge clk) begin
        rsp_t e;
        if (m0_rvalid === 1'b1) begin
            if (q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rsp0_unexpected @cycle %0d: got rvalid with rdata %h, expected none", cycle, m0_rdata);
            end else begin
                e = q0.pop_front();
                chk("rsp0_cycle", 32'(cycle), 32'(e.cyc));
                chk("rsp0_rdata", m0_rdata, e.data);
            end
        end
        if (m1_rvalid === 1'b1) begin
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rsp1_unexpected @cycle %0d: got rvalid with rdata %h, expected none", cycle, m1_rdata);
            end else begin
                e = q1.pop_front();
                chk("rsp1_cycle", 32'(cycle), 32'(e.cyc));
                chk("rsp1_rdata", m1_rdata, e.data);
            end
        end
    end

    logic [15:0] mem_addr [10];
    logic [31:0] mem_exp  [10];

    initial begin
        rst = 1'b1; mem_load = 1'b1;
        m0_valid = 1'b0; m0_addr = '0; m0_we = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_we = '0; m1_wdata = '0; m1_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_ready",  32'(m0_ready),  32'h0);
        chk("rst_m1_ready",  32'(m1_ready),  32'h0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
        chk("rst_m0_rdata",  m0_rdata,       32'h0);
        chk("rst_m1_rdata",  m1_rdata,       32'h0);
        chk("rst_m1_busy",   32'(m1_busy),   32'h0);
        chk("rst_dram_we",   32'(dram_we),   32'h0);
        chk("rst_dram_a",    32'(dram_a),    32'h0);
        chk("rst_dram_d",    dram_d,         32'h0);
        rst = 1'b0; mem_load = 1'b0;

        // Alternating grants: both ports reading, port 0 wins first conflict.
        cyc(0, 1, 32'h10, 4'h0, 0, 1, 32'h20, 4'h0, 0, 8'h0, 0, 16'h0004, 32'hC0DE0004, 0);
        cyc(0, 1, 32'h10, 4'h0, 0, 1, 32'h20, 4'h0, 0, 8'h0, 1, 16'h0008, 32'hC0DE0008, 0);
        cyc(0, 1, 32'h10, 4'h0, 0, 1, 32'h20, 4'h0, 0, 8'h0, 0, 16'h0004, 32'hC0DE0004, 0);
        cyc(0, 1, 32'h10, 4'h0, 0, 1, 32'h20, 4'h0, 0, 8'h0, 1, 16'h0008, 32'hC0DE0008, 0);
        idle(0);

        // Write with byte lanes 0 and 2, then read back.
        cyc(0, 1, 32'h40, 4'b0101, 32'hAABBCCDD, 0, 0, 4'h0, 0, 8'h0, 0, 16'h0010, 32'h11223344, 0);
        cyc(0, 1, 32'h40, 4'h0, 0, 0, 0, 4'h0, 0, 8'h0, 0, 16'h0010, 32'h11BB33DD, 0);

        // Burst of 4 writes at word 0x40, stall in the 2nd cycle; port 0 held.
        cyc(0, 1, 32'h10, 4'h0, 0, 1, 32'h100, 4'hF, 32'h1, 8'd3, 1, 16'h0040, 32'hC0DE0040, 0);
        cyc(0, 1, 32'h10, 4'h0, 0, 0, 32'hFFC, 4'hF, 32'h9, 8'd0, -1, 16'h0, 32'h0, 1);
        cyc(0, 1, 32'h10, 4'h0, 0, 1, 32'hFFC, 4'hF, 32'h2, 8'd0, 1, 16'h0041, 32'hC0DE0041, 1);
        cyc(0, 1, 32'h10, 4'h0, 0, 1, 32'hFFC, 4'hF, 32'h3, 8'd0, 1, 16'h0042, 32'hC0DE0042, 1);
        cyc(0, 1, 32'h10, 4'h0, 0, 1, 32'hFFC, 4'hF, 32'h4, 8'd0, 1, 16'h0043, 32'hC0DE0043, 1);
        // Burst ended with last = 1, so port 0 wins the conflict.
        cyc(0, 1, 32'h10, 4'h0, 0, 1, 32'h20, 4'h0, 0, 8'h0, 0, 16'h0004, 32'hC0DE0004, 0);
        cyc(0, 0, 32'h10, 4'h0, 0, 1, 32'h20, 4'h0, 0, 8'h0, 1, 16'h0008, 32'hC0DE0008, 0);
        cyc(0, 1, 32'h10C, 4'h0, 0, 0, 0, 4'h0, 0, 8'h0, 0, 16'h0043, 32'h00000004, 0);

        // Burst read wrapping past the top of the word space.
        cyc(0, 0, 0, 4'h0, 0, 1, 32'h3FFF8, 4'h0, 0, 8'd3, 1, 16'hFFFE, 32'hC0DEFFFE, 0);
        cyc(0, 0, 0, 4'h0, 0, 1, 32'h3FFF8, 4'h0, 0, 8'd0, 1, 16'hFFFF, 32'hC0DEFFFF, 1);
        cyc(0, 0, 0, 4'h0, 0, 1, 32'h3FFF8, 4'h0, 0, 8'd0, 1, 16'h0000, 32'hC0DE0000, 1);
        cyc(0, 0, 0, 4'h0, 0, 1, 32'h3FFF8, 4'h0, 0, 8'd0, 1, 16'h0001, 32'hC0DE0001, 1);
        idle(0);

        // Reset during beat 2 of a 4-beat write burst at word 0x80.
        cyc(0, 0, 0, 4'h0, 0, 1, 32'h200, 4'hF, 32'hA0, 8'd3, 1, 16'h0080, 32'hC0DE0080, 0);
        cyc(0, 0, 0, 4'h0, 0, 1, 32'h200, 4'hF, 32'hA1, 8'd0, 1, 16'h0081, 32'hC0DE0081, 1);
        cyc(1, 0, 0, 4'h0, 0, 1, 32'h200, 4'hF, 32'hA2, 8'd0, -1, 16'h0, 32'h0, 1);
        idle(0);
        cyc(0, 1, 32'h208, 4'h0, 0, 0, 0, 4'h0, 0, 8'h0, 0, 16'h0082, 32'hC0DE0082, 0);
        cyc(0, 1, 32'h204, 4'h0, 0, 0, 0, 4'h0, 0, 8'h0, 0, 16'h0081, 32'h000000A1, 0);
        idle(0);
        idle(0);
        idle(0);

        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);

        mem_addr = '{16'h0010, 16'h0040, 16'h0041, 16'h0042, 16'h0043,
                     16'h0080, 16'h0081, 16'h0082, 16'h0083, 16'hFFFE};
        mem_exp  = '{32'h11BB33DD, 32'h1, 32'h2, 32'h3, 32'h4,
                     32'hA0, 32'hA1, 32'hC0DE0082, 32'hC0DE0083, 32'hC0DEFFFE};
        for (int unsigned k = 0; k < 10; k++)
            chk($sformatf("mem[%h]", mem_addr[k]), mem[mem_addr[k]], mem_exp[k]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
